// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo and its serial transmitter.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last clock of each bit.
// tick_next looks one clock ahead so callers can register outputs that must
// line up with the tick cycle.
module baud_tick_gen #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst_,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'((BAUD_DIV > 1) ? (BAUD_DIV - 2) : 0);

  logic [CW-1:0] count;

  // Free-running bit-period counter, held at zero while cleared
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Boundary flags decoded from the counter register
  always_comb begin
    tick      = (count == LAST);
    tick_next = (BAUD_DIV == 1) ? 1'b1 : (!clear && (count == PRE));
  end

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from the fifo and sends each as a serial frame:
// start bit, WIDTH data bits LSB first, optional even parity, stop bit.
module fifo_tx_serializer
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_empty,
  output logic             fifo_read,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [BCW-1:0]   bit_cnt;
  logic             parity_bit;
  logic             baud_clear;
  logic             tick;
  logic             tick_next;

  // The bit timer only runs while a frame is on the line, so it starts
  // every frame from zero on START entry.
  assign baud_clear = (state == IDLE) || (state == REQ) || (state == LOAD);
  assign shift_next = shift_reg >> 1;

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk      (clk),
    .rst_     (rst_),
    .clear    (baud_clear),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; enable and fifo_empty matter only in IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable && !fifo_empty) state_next = REQ;
      REQ:     state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && (bit_cnt == LAST_BIT))
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded outputs: the pop request can only come from REQ
  always_comb begin
    fifo_read = (state == REQ);
    tx_busy   = (state != IDLE);
  end

  // Registered line driver: each bit value is loaded on the edge that
  // enters its period, so tx_serial changes exactly at bit boundaries.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= (state_next == STOP) && tick_next;
      unique case (state)
        LOAD: begin
          shift_reg  <= fifo_data_out;
          parity_bit <= ^fifo_data_out;
          bit_cnt    <= '0;
          tx_serial  <= 1'b0;
        end
        START: begin
          if (tick) tx_serial <= shift_reg[0];
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              tx_serial <= (PARITY_EN != 0) ? parity_bit : 1'b1;
            end else begin
              shift_reg <= shift_next;
              tx_serial <= shift_next[0];
              bit_cnt   <= bit_cnt + BCW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) tx_serial <= 1'b1;
        end
        default: begin
          tx_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule
